debug_step_ctrl: RTL and testbench



---
 rtl/debug_step_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_debug_step_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: front-panel controller for the pipelined-processor board.
// Synchronizes and debounces the slide switches and two push buttons, then
// drives the register-select word, the processor clock-enable (single-step or
// free-run) and a 16-bit count of issued steps. All outputs are registered.
// DEBOUNCE_CYCLES must be at least 2; RUN_PERIOD must be at least 1.
module debug_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_PERIOD      = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_step,
  input  logic        btn_mode,
  input  logic [5:0]  switch_raw,
  output logic [5:0]  switch,
  output logic        step_en,
  output logic        run_mode,
  output logic [15:0] step_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_W = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(RUN_PERIOD - 1);

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Two-flop synchronizers; bit 1 is the synchronized value.
  logic [1:0]      step_sync;
  logic [1:0]      mode_sync;
  logic [5:0]      sw_sync1;
  logic [5:0]      sw_sync2;
  logic [5:0]      sw_prev;

  // Debouncer state.
  logic            step_stable;
  logic            step_stable_next;
  logic [DB_W-1:0] step_cnt;
  logic [DB_W-1:0] step_cnt_next;
  logic            mode_stable;
  logic            mode_stable_next;
  logic [DB_W-1:0] mode_cnt;
  logic [DB_W-1:0] mode_cnt_next;
  logic [5:0]      sw_stable_next;
  logic [DB_W-1:0] sw_cnt;
  logic [DB_W-1:0] sw_cnt_next;

  // Rising-edge pulses of the debounced buttons.
  logic            step_pulse;
  logic            mode_pulse;

  // Mode FSM.
  state_t          state;
  state_t          state_next;
  logic [RP_W-1:0] period;
  logic [RP_W-1:0] period_next;
  logic            step_en_next;

  // Bring every raw input into the clock domain through two flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_sync <= 2'b00;
      mode_sync <= 2'b00;
      sw_sync1  <= 6'h00;
      sw_sync2  <= 6'h00;
      sw_prev   <= 6'h00;
    end else begin
      step_sync <= {step_sync[0], btn_step};
      mode_sync <= {mode_sync[0], btn_mode};
      sw_sync1  <= switch_raw;
      sw_sync2  <= sw_sync1;
      sw_prev   <= sw_sync2;
    end
  end

  // Step button debouncer: accept a new level once it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    step_stable_next = step_stable;
    step_cnt_next    = step_cnt;
    if (step_sync[1] == step_stable) begin
      step_cnt_next = '0;
    end else if (step_cnt == DB_LAST) begin
      step_stable_next = step_sync[1];
      step_cnt_next    = '0;
    end else begin
      step_cnt_next = step_cnt + DB_W'(1);
    end
  end

  // Mode button debouncer, same rule as the step button.
  always_comb begin
    mode_stable_next = mode_stable;
    mode_cnt_next    = mode_cnt;
    if (mode_sync[1] == mode_stable) begin
      mode_cnt_next = '0;
    end else if (mode_cnt == DB_LAST) begin
      mode_stable_next = mode_sync[1];
      mode_cnt_next    = '0;
    end else begin
      mode_cnt_next = mode_cnt + DB_W'(1);
    end
  end

  // Switch word debouncer: a change of the synced word while counting restarts
  // the count, with the cycle of the change counting as the first of the new run.
  always_comb begin
    sw_stable_next = switch;
    sw_cnt_next    = sw_cnt;
    if (sw_sync2 == switch) begin
      sw_cnt_next = '0;
    end else if (sw_sync2 != sw_prev) begin
      sw_cnt_next = DB_W'(1);
    end else if (sw_cnt == DB_LAST) begin
      sw_stable_next = sw_sync2;
      sw_cnt_next    = '0;
    end else begin
      sw_cnt_next = sw_cnt + DB_W'(1);
    end
  end

  // Debouncer registers and registered rising-edge pulses (aligned with the stable update).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_stable <= 1'b0;
      step_cnt    <= '0;
      mode_stable <= 1'b0;
      mode_cnt    <= '0;
      switch      <= 6'h00;
      sw_cnt      <= '0;
      step_pulse  <= 1'b0;
      mode_pulse  <= 1'b0;
    end else begin
      step_stable <= step_stable_next;
      step_cnt    <= step_cnt_next;
      mode_stable <= mode_stable_next;
      mode_cnt    <= mode_cnt_next;
      switch      <= sw_stable_next;
      sw_cnt      <= sw_cnt_next;
      step_pulse  <= step_stable_next & ~step_stable;
      mode_pulse  <= mode_stable_next & ~mode_stable;
    end
  end

  // Mode FSM next state: mode pulses win over step pulses and over period wraps.
  always_comb begin
    state_next   = state;
    period_next  = period;
    step_en_next = 1'b0;
    case (state)
      ST_STEP: begin
        if (mode_pulse) begin
          state_next  = ST_RUN;
          period_next = '0;
        end else if (step_pulse) begin
          step_en_next = 1'b1;
        end else begin
          step_en_next = 1'b0;
        end
      end
      ST_RUN: begin
        if (mode_pulse) begin
          state_next  = ST_STEP;
          period_next = '0;
        end else if (period == RP_LAST) begin
          period_next  = '0;
          step_en_next = 1'b1;
        end else begin
          period_next = period + RP_W'(1);
        end
      end
      default: begin
        state_next  = ST_STEP;
        period_next = '0;
      end
    endcase
  end

  // FSM state, period counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_STEP;
      period     <= '0;
      step_en    <= 1'b0;
      run_mode   <= 1'b0;
      step_count <= 16'h0000;
    end else begin
      state      <= state_next;
      period     <= period_next;
      step_en    <= step_en_next;
      run_mode   <= (state_next == ST_RUN);
      step_count <= step_count + {15'd0, step_en};
    end
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl with DEBOUNCE_CYCLES=4, RUN_PERIOD=5.
// Expected step_en cycles go into a scoreboard queue when stimulus is driven;
// a negedge monitor pops and compares them as pulses appear. A second instance
// with RUN_PERIOD=1 exercises the 16-bit step counter wrap quickly.
module tb_debug_step_ctrl;

  localparam int DB = 4;
  localparam int RP = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_step = 1'b0;
  logic        btn_mode = 1'b0;
  logic [5:0]  switch_raw = 6'h00;
  logic [5:0]  switch;
  logic        step_en;
  logic        run_mode;
  logic [15:0] step_count;

  logic        btn_mode2 = 1'b0;
  logic [5:0]  switch2;
  logic        step_en2;
  logic        run_mode2;
  logic [15:0] step_count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  debug_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_PERIOD(RP)) dut (
    .clock(clock), .reset(reset), .btn_step(btn_step), .btn_mode(btn_mode),
    .switch_raw(switch_raw), .switch(switch), .step_en(step_en),
    .run_mode(run_mode), .step_count(step_count)
  );

  debug_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_PERIOD(1)) dut_wrap (
    .clock(clock), .reset(reset), .btn_step(1'b0), .btn_mode(btn_mode2),
    .switch_raw(6'h00), .switch(switch2), .step_en(step_en2),
    .run_mode(run_mode2), .step_count(step_count2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every step_en pulse must match the head of the queue.
  always @(negedge clock) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL step_en_missing: no pulse at cycle %0d (now %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (step_en === 1'b1) begin
        checks++;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
        end else begin
          errors++;
          $display("FAIL step_en_unexpected: step_en=1 at cycle %0d, required 0", cyc);
        end
      end
    end
  end

  task automatic tick_to(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    btn_step  = 1'b0;
    btn_mode  = 1'b0;
    btn_mode2 = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({switch, step_en, run_mode, step_count} !== 24'h0) begin
      errors++;
      $display("FAIL reset_immediate: sw=%h en=%b run=%b cnt=%h, required all 0",
               switch, step_en, run_mode, step_count);
    end
    checks++;
    if ({run_mode2, step_count2} !== 17'h0) begin
      errors++;
      $display("FAIL reset_immediate_wrap: run=%b cnt=%h, required 0", run_mode2, step_count2);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({switch, step_en, run_mode, step_count} !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold: sw=%h en=%b run=%b cnt=%h, required all 0",
                 switch, step_en, run_mode, step_count);
      end
    end
    do_reset();
  endtask

  task automatic test_switch();
    int n;
    n = cyc;
    switch_raw = 6'h15;
    tick_to(n + DB + 1);
    checks++;
    if (switch !== 6'h00) begin
      errors++;
      $display("FAIL switch_early: got %h, required 00", switch);
    end
    tick_to(n + DB + 2);
    checks++;
    if (switch !== 6'h15) begin
      errors++;
      $display("FAIL switch_latency: got %h, required 15", switch);
    end
    // 3-cycle glitch must be rejected.
    tick_to(n + 10);
    n = cyc;
    switch_raw = 6'h3F;
    tick_to(n + 3);
    switch_raw = 6'h15;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      checks++;
      if (switch !== 6'h15) begin
        errors++;
        $display("FAIL switch_glitch: got %h, required 15", switch);
      end
    end
    // A change mid-count restarts the count for the new word.
    n = cyc;
    switch_raw = 6'h0A;
    tick_to(n + 2);
    switch_raw = 6'h0B;
    tick_to(n + 7);
    checks++;
    if (switch !== 6'h15) begin
      errors++;
      $display("FAIL switch_restart_early: got %h, required 15", switch);
    end
    tick_to(n + 8);
    checks++;
    if (switch !== 6'h0B) begin
      errors++;
      $display("FAIL switch_restart: got %h, required 0b", switch);
    end
  endtask

  task automatic test_single_step();
    int p;
    for (int k = 0; k < 2; k++) begin
      p = cyc;
      btn_step = 1'b1;
      exp_q.push_back(p + DB + 3);
      tick_to(p + DB + 2);
      checks++;
      if (step_en !== 1'b0) begin
        errors++;
        $display("FAIL step_early: step_en=%b, required 0", step_en);
      end
      tick_to(p + DB + 3);
      checks++;
      if (step_en !== 1'b1) begin
        errors++;
        $display("FAIL step_latency: step_en=%b, required 1", step_en);
      end
      tick_to(p + DB + 4);
      checks++;
      if (step_en !== 1'b0) begin
        errors++;
        $display("FAIL step_width: step_en=%b, required 0", step_en);
      end
      tick_to(p + 20);
      btn_step = 1'b0;
      tick_to(p + 32);
    end
    checks++;
    if (step_count !== 16'd2 || run_mode !== 1'b0) begin
      errors++;
      $display("FAIL step_count_single: cnt=%0d run=%b, required 2 and 0", step_count, run_mode);
    end
  endtask

  task automatic test_free_run();
    int m;
    int m2;
    int k;
    do_reset();
    m  = cyc;
    m2 = m + 60;
    btn_mode = 1'b1;
    k = 1;
    while (m + DB + 3 + RP * k <= m2 + DB + 2) begin
      exp_q.push_back(m + DB + 3 + RP * k);
      k++;
    end
    tick_to(m + DB + 2);
    checks++;
    if (run_mode !== 1'b0) begin
      errors++;
      $display("FAIL run_early: run_mode=%b, required 0", run_mode);
    end
    tick_to(m + DB + 3);
    checks++;
    if (run_mode !== 1'b1) begin
      errors++;
      $display("FAIL run_enter: run_mode=%b, required 1", run_mode);
    end
    tick_to(m + 10);
    btn_mode = 1'b0;
    tick_to(m + 20);
    btn_step = 1'b1;
    tick_to(m + 30);
    btn_step = 1'b0;
    tick_to(m + DB + 3 + RP * 10 + 1);
    checks++;
    if (step_count !== 16'd10) begin
      errors++;
      $display("FAIL run_count10: cnt=%0d, required 10", step_count);
    end
    tick_to(m2);
    btn_mode = 1'b1;
    tick_to(m2 + DB + 2);
    checks++;
    if (run_mode !== 1'b1) begin
      errors++;
      $display("FAIL run_exit_early: run_mode=%b, required 1", run_mode);
    end
    tick_to(m2 + DB + 3);
    checks++;
    if (run_mode !== 1'b0) begin
      errors++;
      $display("FAIL run_exit: run_mode=%b, required 0", run_mode);
    end
    tick_to(m2 + 10);
    btn_mode = 1'b0;
    tick_to(m2 + 30);
    checks++;
    if (step_count !== 16'(k - 1)) begin
      errors++;
      $display("FAIL run_count_final: cnt=%0d, required %0d", step_count, k - 1);
    end
  endtask

  task automatic test_simultaneous();
    int s;
    do_reset();
    s = cyc;
    btn_step = 1'b1;
    btn_mode = 1'b1;
    tick_to(s + DB + 3);
    checks++;
    if (run_mode !== 1'b1 || step_en !== 1'b0) begin
      errors++;
      $display("FAIL simul_mode: run=%b en=%b, required 1 and 0", run_mode, step_en);
    end
    tick_to(s + DB + 4);
    checks++;
    if (step_count !== 16'd0) begin
      errors++;
      $display("FAIL simul_count: cnt=%0d, required 0", step_count);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    int c;
    int e;
    c = cyc;
    e = c + DB + 3;
    btn_mode2 = 1'b1;
    tick_to(e);
    checks++;
    if (run_mode2 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_run: run_mode=%b, required 1", run_mode2);
    end
    tick_to(c + 10);
    btn_mode2 = 1'b0;
    tick_to(e + 65536);
    checks++;
    if (step_count2 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: cnt=%h, required ffff", step_count2);
    end
    tick_to(e + 65537);
    checks++;
    if (step_count2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: cnt=%h, required 0000", step_count2);
    end
    tick_to(e + 65538);
    checks++;
    if (step_count2 !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_after: cnt=%h, required 0001", step_count2);
    end
  endtask

  task automatic test_reset_mid_period();
    int m;
    int r;
    do_reset();
    m = cyc;
    btn_mode = 1'b1;
    tick_to(m + DB + 5);
    // Period counter is partway through its count here.
    do_reset();
    r = cyc;
    btn_mode = 1'b1;
    exp_q.push_back(r + DB + 3 + RP);
    tick_to(r + DB + 3 + RP - 1);
    checks++;
    if (step_en !== 1'b0 || run_mode !== 1'b1) begin
      errors++;
      $display("FAIL midreset_early: en=%b run=%b, required 0 and 1", step_en, run_mode);
    end
    tick_to(r + DB + 3 + RP);
    checks++;
    if (step_en !== 1'b1) begin
      errors++;
      $display("FAIL midreset_first: step_en=%b, required 1", step_en);
    end
    tick_to(r + DB + 3 + RP + 1);
    do_reset();
  endtask

  initial begin
    test_reset();
    test_switch();
    test_single_step();
    test_free_run();
    test_simultaneous();
    test_wrap();
    test_reset_mid_period();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
